// File: rtl/audiouart_ocimem_arb_pkg.sv
// audiouart_ocimem_arb_pkg: shared types and constants for the OCI RAM arbiter.
package audiouart_ocimem_arb_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_JTAG = 1'b1;
    typedef enum logic [1:0] {IDLE, ACC, RD, RESP} state_e;
endpackage

// File: rtl/audiouart_ocimem_rr_pick.sv
// audiouart_ocimem_rr_pick: two-way picker, debugack gives JTAG the tie, else round-robin.
module audiouart_ocimem_rr_pick
    import audiouart_ocimem_arb_pkg::*;
(
    input  logic cpu_pend,
    input  logic jtag_pend,
    input  logic debugack,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);
    assign grant_valid = cpu_pend | jtag_pend;
    assign grant_id = (jtag_pend && (!cpu_pend || debugack || (last_grant == GNT_CPU))) ? GNT_JTAG : GNT_CPU;
endmodule

// File: rtl/audiouart_ocimem_arbiter.sv
// audiouart_ocimem_arbiter: shares the OCI debug RAM between the CPU slave and JTAG command path.
// AUDIOUART_OCIMEM_AUTOINC_EN: JTAG pointer advances after each completed JTAG access.
module audiouart_ocimem_arbiter
    import audiouart_ocimem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              debugack,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    input  logic              jtag_valid,
    input  logic              jtag_write,
    input  logic              jtag_addr_load,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q;
    logic              gnt_q, last_q, wr_q;
    logic [ADDR_W-1:0] ptr_q, mem_addr_q;
    logic [DATA_W-1:0] ard_q, jrd_q, mem_wdata_q;
    logic              wait_q, done_q, mem_en_q, mem_wr_q;
    logic              grant_valid, grant_id, req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    audiouart_ocimem_rr_pick u_pick (
        .cpu_pend   (avs_read | avs_write),
        .jtag_pend  (jtag_valid),
        .debugack   (debugack),
        .last_grant (last_q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    // read+write together from the CPU counts as a write
    assign req_wr    = (grant_id == GNT_JTAG) ? jtag_write : avs_write;
    assign req_addr  = (grant_id == GNT_JTAG) ? ptr_q : avs_address;
    assign req_wdata = (grant_id == GNT_JTAG) ? jtag_wdata : avs_writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_CPU;
            last_q      <= GNT_JTAG;
            wr_q        <= 1'b0;
            wait_q      <= 1'b1;
            done_q      <= 1'b0;
            ard_q       <= '0;
            jrd_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (grant_valid) begin
                    gnt_q       <= grant_id;
                    last_q      <= grant_id;
                    wr_q        <= req_wr;
                    mem_en_q    <= 1'b1;
                    mem_wr_q    <= req_wr;
                    mem_addr_q  <= req_addr;
                    mem_wdata_q <= req_wdata;
                    wait_q      <= !(req_wr && grant_id == GNT_CPU);
                    done_q      <= req_wr && grant_id == GNT_JTAG;
                    state_q     <= ACC;
                end
                ACC: begin
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    wait_q   <= 1'b1;
                    done_q   <= 1'b0;
                    state_q  <= wr_q ? IDLE : RD;
                end
                RD: begin
                    if (gnt_q == GNT_CPU) ard_q <= mem_rdata;
                    else jrd_q <= mem_rdata;
                    wait_q  <= gnt_q != GNT_CPU;
                    done_q  <= gnt_q == GNT_JTAG;
                    state_q <= RESP;
                end
                default: begin
                    wait_q  <= 1'b1;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // a load in the completion cycle wins over the auto-increment
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else if (jtag_addr_load) ptr_q <= jtag_addr;
`ifdef AUDIOUART_OCIMEM_AUTOINC_EN
        else if (done_q) ptr_q <= ptr_q + ADDR_W'(1);
`else
        else ptr_q <= ptr_q;
`endif
    end

    assign avs_readdata    = ard_q;
    assign avs_waitrequest = wait_q;
    assign jtag_rdata      = jrd_q;
    assign jtag_done       = done_q;
    assign mem_en          = mem_en_q;
    assign mem_wr          = mem_wr_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
endmodule
